// File: rtl/muldiv_seq.sv
// Multi-cycle MUL / signed DIV sequencer that runs beside the single-cycle ALU.
// One iteration per cycle: shift-add for MUL, restoring division on magnitudes
// for DIV. The quotient sign is applied in FIX, and the result is published in DONE.
module muldiv_seq #(
    parameter int         WIDTH  = 32,
    parameter logic [4:0] OP_MUL = 5'b00110,
    parameter logic [4:0] OP_DIV = 5'b01000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       flags,
    output logic             div0
);

    // One extra bit so the counter can hold WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   rem_r;      // MUL accumulator (low bits) / DIV partial remainder
    logic [WIDTH-1:0] opa_r;      // MUL multiplicand / DIV dividend shifting into quotient
    logic [WIDTH-1:0] opb_r;      // MUL multiplier / DIV divisor magnitude
    logic             is_div_r;
    logic             neg_r;
    logic             busy_r, done_r, div0_r;
    logic [WIDTH-1:0] result_r;
    logic [1:0]       flags_r;

    logic             op_ok_s, accept_s, div_zero_s;
    logic [WIDTH-1:0] mul_sum_s;
    logic [WIDTH:0]   rem_sh_s, diff_s;
    logic [WIDTH-1:0] fix_res_s;

    // Two's-complement magnitude; the most-negative value maps to itself as an unsigned value.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
    endfunction

    // N and Z flags of a result word.
    function automatic logic [1:0] flags_of(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == '0)};
    endfunction

    // Request decode: flush in IDLE blocks acceptance.
    always_comb begin
        op_ok_s    = (opcode == OP_MUL) || (opcode == OP_DIV);
        accept_s   = (state_r == ST_IDLE) && start && !flush && op_ok_s;
        div_zero_s = accept_s && (opcode == OP_DIV) && (b == '0);
    end

    // Per-iteration datapath terms and the FIX-stage result.
    always_comb begin
        mul_sum_s = rem_r[WIDTH-1:0] + (opb_r[0] ? opa_r : '0);
        rem_sh_s  = {rem_r[WIDTH-1:0], opa_r[WIDTH-1]};
        diff_s    = rem_sh_s - {1'b0, opb_r};
        if (is_div_r) begin
            fix_res_s = neg_r ? ((~opa_r) + WIDTH'(1)) : opa_r;
        end else begin
            fix_res_s = rem_r[WIDTH-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = div_zero_s ? ST_DONE : ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == CW'(WIDTH - 1)) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_CALC) || (state_s == ST_FIX);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Operand latch, iteration datapath and result/flags/div0 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            rem_r    <= '0;
            opa_r    <= '0;
            opb_r    <= '0;
            is_div_r <= 1'b0;
            neg_r    <= 1'b0;
            div0_r   <= 1'b0;
            result_r <= '0;
            flags_r  <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r    <= '0;
                        rem_r    <= '0;
                        is_div_r <= (opcode == OP_DIV);
                        neg_r    <= a[WIDTH-1] ^ b[WIDTH-1];
                        div0_r   <= div_zero_s;
                        if (opcode == OP_DIV) begin
                            opa_r <= abs_val(a);
                            opb_r <= abs_val(b);
                        end else begin
                            opa_r <= a;
                            opb_r <= b;
                        end
                        if (div_zero_s) begin
                            result_r <= '1;
                            flags_r  <= 2'b10;
                        end
                    end
                end
                ST_CALC: begin
                    if (!flush) begin
                        cnt_r <= cnt_r + CW'(1);
                        if (is_div_r) begin
                            rem_r <= diff_s[WIDTH] ? rem_sh_s : diff_s;
                            opa_r <= {opa_r[WIDTH-2:0], ~diff_s[WIDTH]};
                        end else begin
                            rem_r <= {1'b0, mul_sum_s};
                            opa_r <= opa_r << 1;
                            opb_r <= opb_r >> 1;
                        end
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        result_r <= fix_res_s;
                        flags_r  <= flags_of(fix_res_s);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output drive; stall must react to start in the same cycle.
    always_comb begin
        busy   = busy_r;
        done   = done_r;
        result = result_r;
        flags  = flags_r;
        div0   = div0_r;
        stall  = busy_r || accept_s;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, hand-written corner sequences,
// and random MUL/DIV traffic checked against a plain-arithmetic model.
module tb_muldiv_seq;

    localparam int         W      = 32;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b01000;

    logic         clk, rst_n, start, flush;
    logic [4:0]   opcode;
    logic [W-1:0] a, b;
    logic         busy, stall, done, div0;
    logic [W-1:0] result;
    logic [1:0]   flags;

    int errors = 0;
    int checks = 0;

    muldiv_seq #(.WIDTH(W), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .a(a), .b(b), .flush(flush), .busy(busy), .stall(stall),
        .done(done), .result(result), .flags(flags), .div0(div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] exp_res;
        logic [1:0]   exp_flags;
        logic         exp_div0;
        int           exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: low W bits of product; signed quotient truncated toward zero.
    task automatic model(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] r, output logic [1:0] f, output logic d0, output int lat);
        longint sa, sb, q;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        d0 = 1'b0;
        lat = W + 2;
        if (op == OP_MUL) begin
            p = 64'(av) * 64'(bv);
            r = p[W-1:0];
        end else if (bv == '0) begin
            r = '1;
            d0 = 1'b1;
            lat = 1;
        end else begin
            q = sa / sb;
            r = q[W-1:0];
        end
        f = {r[W-1], (r == '0)};
    endtask

    // Issue one op at cycle 0 and wait (bounded) for done; lat = cycle index of done.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W-1:0] r, output logic [1:0] f, output logic d0,
                          output int lat, output logic busy_seen);
        start = 1'b1; opcode = op; a = av; b = bv;
        #1;
        chk("stall_on_start", 64'(stall), 64'd1);
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 1;
        busy_seen = busy;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
            busy_seen = busy_seen | busy;
        end
        if (lat >= 100) chk("done_timeout", 64'(done), 64'd1);
        r = result; f = flags; d0 = div0;
    endtask

    vec_t         vecs[8];
    logic [W-1:0] r, mr, prev;
    logic [1:0]   f, mf;
    logic         d0, md0, bs;
    int           lat, mlat;
    logic [4:0]   rop;
    logic [W-1:0] ra, rb;

    initial begin
        vecs[0] = '{OP_MUL, 32'd7,          32'd6,          32'd42,         2'b00, 1'b0, 34};
        vecs[1] = '{OP_DIV, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  2'b10, 1'b0, 34};
        vecs[2] = '{OP_DIV, 32'd5,          32'd0,          32'hFFFF_FFFF,  2'b10, 1'b1, 1};
        vecs[3] = '{OP_DIV, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2'b10, 1'b0, 34};
        vecs[4] = '{OP_MUL, 32'h0001_0000,  32'h0001_0000,  32'd0,          2'b01, 1'b0, 34};
        vecs[5] = '{OP_DIV, 32'd100,        32'd7,          32'd14,         2'b00, 1'b0, 34};
        vecs[6] = '{OP_DIV, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         2'b00, 1'b0, 34};
        vecs[7] = '{OP_DIV, 32'd3,          32'd7,          32'd0,          2'b01, 1'b0, 34};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; opcode = 5'd0; a = '0; b = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_div0", 64'(div0), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].av, vecs[i].bv, r, f, d0, lat, bs);
            chk($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].exp_res));
            chk($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].exp_flags));
            chk($sformatf("vec%0d_div0", i), 64'(d0), 64'(vecs[i].exp_div0));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_busy_seen", i), 64'(bs), 64'(vecs[i].exp_lat > 1));
            tick();
            chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
            chk($sformatf("vec%0d_result_hold", i), 64'(result), 64'(vecs[i].exp_res));
        end

        // Non-MUL/DIV opcode is ignored.
        start = 1'b1; opcode = 5'b00001; a = 32'd1; b = 32'd1;
        #1;
        chk("other_op_stall", 64'(stall), 64'd0);
        tick(); start = 1'b0;
        chk("other_op_busy", 64'(busy), 64'd0);

        // Flush beats start in IDLE.
        start = 1'b1; flush = 1'b1; opcode = OP_MUL;
        #1;
        chk("idle_flush_stall", 64'(stall), 64'd0);
        tick(); start = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", 64'(busy), 64'd0);

        // Start in DONE is ignored and stall is 0 there.
        run_op(OP_MUL, 32'd5, 32'd5, r, f, d0, lat, bs);
        chk("done_seq_result", 64'(r), 64'd25);
        start = 1'b1; opcode = OP_MUL; a = 32'd9; b = 32'd9;
        #1;
        chk("done_stall", 64'(stall), 64'd0);
        #1; start = 1'b0;
        tick();
        chk("done_start_ignored_a", 64'(busy), 64'd0);
        tick();
        chk("done_start_ignored_b", 64'(busy), 64'd0);

        // Flush mid-CALC: no done, result unchanged; a new MUL afterwards works.
        prev = result;
        start = 1'b1; opcode = OP_MUL; a = 32'd3; b = 32'd4;
        tick(); start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        tick(); flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) chk("flush_no_done", 64'(done), 64'd0);
            tick();
        end
        chk("flush_result_kept", 64'(result), 64'(prev));
        run_op(OP_MUL, 32'd2, 32'd2, r, f, d0, lat, bs);
        chk("after_flush_result", 64'(r), 64'd4);
        chk("after_flush_latency", 64'(lat), 64'd34);
        tick();

        // Start while busy is ignored.
        start = 1'b1; opcode = OP_DIV; a = 32'd100; b = 32'd7;
        tick(); start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        start = 1'b1; opcode = OP_MUL; a = 32'd9; b = 32'd9;
        #1;
        chk("busy_start_stall", 64'(stall), 64'd1);
        tick(); start = 1'b0;
        lat = 6;
        while (done !== 1'b1 && lat < 100) begin tick(); lat++; end
        chk("busy_start_result", 64'(result), 64'd14);
        chk("busy_start_latency", 64'(lat), 64'd34);
        tick();

        // Async reset mid-CALC.
        start = 1'b1; opcode = OP_DIV; a = 32'd100; b = 32'd7;
        tick(); start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_flags", 64'(flags), 64'd0);
        chk("midrst_div0", 64'(div0), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) chk("midrst_quiet", 64'({busy, done}), 64'd0);
            tick();
        end

        // Random traffic against the model.
        for (int i = 0; i < 30; i++) begin
            rop = ($urandom_range(1, 0) == 1) ? OP_DIV : OP_MUL;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(4, 0))
                0: rb = '0;
                1: rb = W'($urandom_range(20, 1));
                2: rb = -W'($urandom_range(20, 1));
                3: ra = W'($urandom_range(1000, 0));
                default: ;
            endcase
            model(rop, ra, rb, mr, mf, md0, mlat);
            run_op(rop, ra, rb, r, f, d0, lat, bs);
            chk($sformatf("rnd%0d_result op=%0h a=%0h b=%0h", i, rop, ra, rb), 64'(r), 64'(mr));
            chk($sformatf("rnd%0d_flags", i), 64'(f), 64'(mf));
            chk($sformatf("rnd%0d_div0", i), 64'(d0), 64'(md0));
            chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(mlat));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
